// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: sync, DE, coordinates and line/frame pulses
// behind an OUT_LATENCY-deep enabled pipeline. Define VTG_TEST_PATTERN_EN for colour bars.
module video_timing_gen #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter logic        HS_POL      = 1'b1,
    parameter logic        VS_POL      = 1'b1,
    parameter int unsigned OUT_LATENCY = 1,
    parameter int unsigned CNT_W       = 12
) (
    input  logic             pixclk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             restart,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start,
    output logic [7:0]       red,
    output logic [7:0]       green,
    output logic [7:0]       blue
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned CNT_LIM  = 32'd1 << CNT_W;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SS     = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SE     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SS     = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SE     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    // Elaboration-time parameter guards
    if (OUT_LATENCY < 1 || OUT_LATENCY > 8) begin : g_bad_latency
        $error("video_timing_gen: OUT_LATENCY must be in 1..8");
    end
    if (H_TOTAL >= CNT_LIM || V_TOTAL >= CNT_LIM) begin : g_bad_total
        $error("video_timing_gen: raster totals do not fit in CNT_W bits");
    end

    typedef struct packed {
        logic             hs;
        logic             vs;
        logic             de;
        logic             ls;
        logic             fs;
        logic [CNT_W-1:0] x;
        logic [CNT_W-1:0] y;
    } stage_t;

    localparam int unsigned STAGE_W = $bits(stage_t);
    localparam int unsigned PIPE_W  = OUT_LATENCY * STAGE_W;
    localparam stage_t STAGE_RST = '{hs: ~HS_POL, vs: ~VS_POL, de: 1'b0, ls: 1'b0,
                                     fs: 1'b0, x: '0, y: '0};

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    stage_t           stage0_c;
    stage_t [OUT_LATENCY-1:0] pipe;

    // Raster counters; restart and natural wrap both land on 0,0
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (en) begin
            if (restart) begin
                h_cnt <= '0;
                v_cnt <= '0;
            end else if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
            end else begin
                h_cnt <= h_cnt + CNT_W'(1);
            end
        end
    end

    // Stage-0 decode of the current position
    always_comb begin
        stage0_c    = STAGE_RST;
        stage0_c.de = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        stage0_c.hs = ((h_cnt >= H_SS) && (h_cnt < H_SE)) ? HS_POL : ~HS_POL;
        stage0_c.vs = ((v_cnt >= V_SS) && (v_cnt < V_SE)) ? VS_POL : ~VS_POL;
        stage0_c.ls = (h_cnt == '0);
        stage0_c.fs = (h_cnt == '0) && (v_cnt == '0);
        stage0_c.x  = h_cnt;
        stage0_c.y  = v_cnt;
    end

    // Output pipeline: element 0 is the newest stage, the top element drives the ports
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= {OUT_LATENCY{STAGE_RST}};
        end else if (en) begin
            pipe <= PIPE_W'({pipe, stage0_c});
        end
    end

    assign hsync       = pipe[OUT_LATENCY-1].hs;
    assign vsync       = pipe[OUT_LATENCY-1].vs;
    assign de          = pipe[OUT_LATENCY-1].de;
    assign line_start  = pipe[OUT_LATENCY-1].ls;
    assign frame_start = pipe[OUT_LATENCY-1].fs;
    assign x           = pipe[OUT_LATENCY-1].x;
    assign y           = pipe[OUT_LATENCY-1].y;

`ifdef VTG_TEST_PATTERN_EN
    localparam int unsigned BAR_W    = (H_ACTIVE / 8 == 0) ? 1 : H_ACTIVE / 8;
    localparam int unsigned RGB_PW   = OUT_LATENCY * 24;

    logic [CNT_W-1:0]          bar_raw_c;
    logic [2:0]                bar_idx_c;
    logic [23:0]               rgb_c;
    logic [OUT_LATENCY-1:0][23:0] rgb_pipe;

    // Bar colour bits: R is off for bars 2,3,6,7, G off for 4..7, B off for odd bars
    always_comb begin
        bar_raw_c = h_cnt / CNT_W'(BAR_W);
        bar_idx_c = (bar_raw_c > CNT_W'(7)) ? 3'd7 : bar_raw_c[2:0];
        rgb_c     = '0;
        if (stage0_c.de) begin
            rgb_c = {{8{~bar_idx_c[1]}}, {8{~bar_idx_c[2]}}, {8{~bar_idx_c[0]}}};
        end
    end

    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_pipe <= '0;
        end else if (en) begin
            rgb_pipe <= RGB_PW'({rgb_pipe, rgb_c});
        end
    end

    assign red   = rgb_pipe[OUT_LATENCY-1][23:16];
    assign green = rgb_pipe[OUT_LATENCY-1][15:8];
    assign blue  = rgb_pipe[OUT_LATENCY-1][7:0];
`else
    assign red   = 8'd0;
    assign green = 8'd0;
    assign blue  = 8'd0;
`endif

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing generator for the pixel-clock domain of the HDMI/DVI transmit path.
- Produces hsync, vsync, data-enable, pixel coordinates and line/frame pulses for any CEA/VESA mode.
- Has a configurable output pipeline delay so sync and DE stay aligned with downstream pixel pipelines.
- Feeds the colour source and the TMDS encoders. Replaces the fixed 640x480 hard-coded counters.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 1, hsync active level (1 = active high)
- VS_POL, 1, vsync active level
- OUT_LATENCY, 1, register stages from counters to outputs (1..8)
- CNT_W, 12, counter and coordinate width

Ports:
- pixclk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  clock enable; all state advances only when en=1
- restart  in  1  synchronous counter restart
- hsync  out  1  horizontal sync, polarity per HS_POL
- vsync  out  1  vertical sync, polarity per VS_POL
- de  out  1  data enable (active area)
- x  out  CNT_W  pixel column, valid when de=1
- y  out  CNT_W  pixel row, valid when de=1
- line_start  out  1  one-cycle pulse at h=0 of every line
- frame_start  out  1  one-cycle pulse at h=0, v=0
- red  out  8  test-pattern red
- green  out  8  test-pattern green
- blue  out  8  test-pattern blue

Behaviour:
- Clock and reset: one clock, pixclk. Reset is asynchronous and active-low on rst_n.
- Totals:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP; V_TOTAL is the analogous vertical sum.
  - Both totals must be < 2^CNT_W.
  - OUT_LATENCY outside 1..8 is an elaboration error.
- Reset values:
  - h_cnt = 0, v_cnt = 0, all pipeline stages inactive.
  - hsync = ~HS_POL, vsync = ~VS_POL.
  - de, line_start, frame_start = 0.
  - x = y = 0, rgb = 0.
- Counting, on each pixclk edge with en=1:
  - h_cnt wraps H_TOTAL-1 -> 0.
  - v_cnt increments only when h_cnt = H_TOTAL-1, and wraps V_TOTAL-1 -> 0.
- Stage-0 decode, combinational from current counts:
  - de0 = h<H_ACTIVE && v<V_ACTIVE.
  - hs0 active iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vs0 active iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
  - vsync changes with the line counter, at h=0 of the line.
  - ls0 = (h==0); fs0 = (h==0 && v==0); x0 = h, y0 = v.
- Pipeline: stage-0 values pass through OUT_LATENCY enabled register stages to the outputs.
  - With OUT_LATENCY=1, outputs show the count held before the edge.
  - Every stage advances only when en=1.
- en=0: counters and pipeline hold and outputs are frozen. No pulse is repeated or lost; pulses simply stretch while en=0.
- restart=1 on an enabled edge:
  - Next h_cnt = 0, v_cnt = 0.
  - Pipeline contents still shift normally, so outputs show the old position for OUT_LATENCY more cycles.
- restart coinciding with a natural wrap gives the same result: 0, 0.
- restart while en=0 is ignored.
- rst_n asserted mid-frame: everything returns to reset values immediately. After release, the first enabled edge starts a fresh frame at 0, 0.
- x and y hold their last stage value outside the active area; downstream must qualify with de.

Optional Feature:
- Macro: VTG_TEST_PATTERN_EN.
- Defined:
  - red/green/blue generate 8 vertical colour bars, aligned with de at the same latency.
  - Bar width BW = H_ACTIVE/8 (integer); bar index = x/BW, saturated at 7.
  - Bar order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - rgb = 0 whenever de=0.
- Not defined: red/green/blue are tied to constant 0 and no pattern logic is synthesised.

Test Plan:
- Reset, then en=1 with defaults: first edge gives de=1, x=0, y=0, frame_start=1, line_start=1. The de-high run lasts exactly 640 cycles.
- Free run with defaults:
  - hsync high during cycles 656..751 of each 800-cycle line.
  - vsync high for exactly 1600 cycles (lines 490..491).
  - frame_start period is exactly 420000 cycles.
- HS_POL=0, VS_POL=0, OUT_LATENCY=4:
  - Syncs are inverted and idle high from reset.
  - Every output edge is delayed 3 cycles relative to the OUT_LATENCY=1 build given the same stimulus.
- en toggled 1,0,0,1 mid-line at x=100: x stays 100 across the two stalled cycles and then reads 101. The total cycle count to frame_start grows by exactly 2.
- restart pulsed at x=300, y=200 (OUT_LATENCY=1): the next edge shows x=300; the following edge shows x=0, y=0, frame_start=1.
- VTG_TEST_PATTERN_EN defined, defaults: at y=10, x=0 gives rgb FFFFFF, x=80 gives FFFF00, x=639 gives 000000, and x=700 gives 000000 with de=0.
